// File: rtl/pair_triple_pattern_gen.sv
// Stimulus generator and checker for a 2-of-3 majority detector: walks all eight
// input patterns (or an LFSR sequence when PTG_LFSR_EN is defined) and counts mismatches.
module pair_triple_pattern_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] num_vecs,
    output logic       vec_val,
    input  logic       vec_rdy,
    output logic       in0,
    output logic       in1,
    output logic       in2,
    output logic       exp,
    input  logic       dut_out,
    output logic [7:0] err_cnt,
    output logic       busy,
    output logic       done
);

    // Handshake: a vector moves on every rising edge where vec_val & vec_rdy; while
    // vec_val=1 and vec_rdy=0 the vector and exp are held unchanged.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [2:0] vec;
    logic [8:0] cnt;
    logic [8:0] cnt_nxt;
    logic [8:0] last_idx;
    logic       xfer;

    assign xfer    = vec_val & vec_rdy;
    assign cnt_nxt = cnt + 9'd1;

`ifdef PTG_LFSR_EN
    logic       mode_q;
    logic [7:0] nv_q;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;

    // Fibonacci LFSR, taps 8,6,5,4 feeding bit 0.
    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign last_idx = !mode_q ? 9'd7 :
                      (nv_q == 8'd0) ? 9'd255 : ({1'b0, nv_q} - 9'd1);
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode, num_vecs};
    assign last_idx   = 9'd7;
`endif

    assign {in2, in1, in0} = vec;
    assign exp  = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec_val <= 1'b0;
            vec     <= 3'd0;
            cnt     <= 9'd0;
            err_cnt <= 8'd0;
`ifdef PTG_LFSR_EN
            mode_q  <= 1'b0;
            nv_q    <= 8'd0;
            lfsr    <= 8'hA5;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        vec_val <= 1'b1;
                        cnt     <= 9'd0;
                        err_cnt <= 8'd0;
`ifdef PTG_LFSR_EN
                        mode_q  <= mode;
                        nv_q    <= num_vecs;
                        lfsr    <= 8'hA5;
                        vec     <= mode ? 3'b101 : 3'd0;
`else
                        vec     <= 3'd0;
`endif
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if ((dut_out != exp) && (err_cnt != 8'hFF))
                            err_cnt <= err_cnt + 8'd1;
                        if (cnt == last_idx) begin
                            state   <= DONE;
                            vec_val <= 1'b0;
                        end else begin
                            cnt <= cnt_nxt;
`ifdef PTG_LFSR_EN
                            lfsr <= lfsr_nxt;
                            vec  <= mode_q ? lfsr_nxt[2:0] : cnt_nxt[2:0];
`else
                            vec  <= cnt_nxt[2:0];
`endif
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    vec_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_triple_pattern_gen.sv
// Self-checking bench for pair_triple_pattern_gen; random-mode scenarios are
// compiled in only when PTG_LFSR_EN is defined.
module tb_pair_triple_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] num_vecs = 8'd0;
    logic       vec_rdy = 1'b0;
    logic       dut_out = 1'b0;
    logic       vec_val, in0, in1, in2, exp, busy, done;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    pair_triple_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vecs(num_vecs),
        .vec_val(vec_val), .vec_rdy(vec_rdy), .in0(in0), .in1(in1), .in2(in2),
        .exp(exp), .dut_out(dut_out), .err_cnt(err_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return $countones(v) >= 2;
    endfunction

    // Detector behaviours: 0 correct, 1 in0&in1, 2 inverted, 3 correct with random flips.
    function automatic logic resp_of(input int det, input logic [2:0] v, input logic flip);
        case (det)
            0:       return maj(v);
            1:       return v[0] & v[1];
            2:       return ~maj(v);
            default: return maj(v) ^ flip;
        endcase
    endfunction

    function automatic void build_exhaustive();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    endfunction

    function automatic void build_random(input logic [7:0] nv);
        int s = 8'hA5;
        int n = (nv == 8'd0) ? 256 : int'(nv);
        int fb;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(3'(s & 7));
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s  = ((s << 1) | fb) & 255;
        end
    endfunction

    task automatic do_start(input logic m, input logic [7:0] nv);
        @(negedge clk);
        start = 1'b1; mode = m; num_vecs = nv; vec_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        mode = 1'($urandom_range(0, 1));
        num_vecs = 8'($urandom);
    endtask

    // Drains exp_q through the handshake; rdy_kind 0 always, 1 toggling, 2 random.
    task automatic run_body(input int rdy_kind, input int det, input int stop_after,
                            input int poke_at, input string name, output int err_o);
        int budget = 4000;
        int xfers = 0;
        int exp_err = 0;
        logic tog = 1'b1;
        logic poked = 1'b0;
        logic [2:0] want;
        logic rdy, flip, model_resp;
        while (exp_q.size() > 0 && budget > 0 && !(stop_after > 0 && xfers == stop_after)) begin
            budget--;
            want = exp_q[0];
            n_vec++;
            if (vec_val !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s run_flags: vec_val=%b busy=%b done=%b, required 1 1 0",
                         name, vec_val, busy, done);
            end
            n_vec++;
            if ({in2, in1, in0} !== want || exp !== maj(want)) begin
                n_err++;
                $display("FAIL %s vector[%0d]: got vec=%0d exp=%b, required vec=%0d exp=%b",
                         name, xfers, {in2, in1, in0}, exp, want, maj(want));
            end
            case (rdy_kind)
                0: rdy = 1'b1;
                1: begin rdy = tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            flip = ($urandom_range(0, 3) == 0);
            model_resp = resp_of(det, want, flip);
            if (poke_at >= 0 && xfers == poke_at && !poked) begin
                start = 1'b1; poked = 1'b1;
            end
            vec_rdy = rdy;
            dut_out = resp_of(det, {in2, in1, in0}, flip);
            if (rdy) begin
                xfers++;
                if (model_resp != maj(want)) exp_err++;
                void'(exp_q.pop_front());
            end
            @(negedge clk);
            start = 1'b0;
        end
        vec_rdy = 1'b0;
        err_o = exp_err;
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL %s timeout: %0d vectors left, required 0", name, exp_q.size());
        end
        if (stop_after == 0) begin
            n_vec++;
            if (vec_val !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s end_flags: vec_val=%b busy=%b done=%b, required 0 0 1",
                         name, vec_val, busy, done);
            end
            n_vec++;
            if (err_cnt !== 8'((exp_err > 255) ? 255 : exp_err)) begin
                n_err++;
                $display("FAIL %s err_cnt: got %0d, required %0d", name, err_cnt,
                         (exp_err > 255) ? 255 : exp_err);
            end
            repeat (2) @(negedge clk);
            n_vec++;
            if (err_cnt !== 8'((exp_err > 255) ? 255 : exp_err) || vec_val !== 1'b0 || done !== 1'b1) begin
                n_err++;
                $display("FAIL %s done_hold: err_cnt=%0d vec_val=%b done=%b, required %0d 0 1",
                         name, err_cnt, vec_val, done, (exp_err > 255) ? 255 : exp_err);
            end
        end
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (vec_val !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_cnt !== 8'd0 ||
            {in2, in1, in0} !== 3'd0) begin
            n_err++;
            $display("FAIL %s idle: vec_val=%b busy=%b done=%b err_cnt=%0d vec=%0d, required all 0",
                     name, vec_val, busy, done, err_cnt, {in2, in1, in0});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("idle_no_start");
    endtask

    task automatic test_exhaustive();
        int e;
        build_exhaustive();
        do_start(1'b0, 8'd0);
        run_body(0, 0, 0, -1, "exhaustive", e);
    endtask

    task automatic test_mismatch();
        int e;
        build_exhaustive();
        do_start(1'b0, 8'd0);
        run_body(0, 1, 0, -1, "mismatch_and", e);
        n_vec++;
        if (e != 2) begin
            n_err++;
            $display("FAIL mismatch_model: got %0d, required 2", e);
        end
    endtask

    task automatic test_stall();
        int e;
        build_exhaustive();
        do_start(1'b0, 8'd0);
        run_body(1, 0, 0, -1, "stall_toggle", e);
    endtask

    task automatic test_random_traffic();
        int e;
        for (int k = 0; k < 4; k++) begin
            build_exhaustive();
            do_start(1'b0, 8'd0);
            run_body(2, 3, 0, -1, "random_traffic", e);
        end
    endtask

    task automatic test_start_during_run();
        int e;
        build_exhaustive();
        do_start(1'b0, 8'd0);
        run_body(2, 0, 0, 4, "start_in_run", e);
    endtask

    task automatic test_reset_mid_run();
        int e;
        build_exhaustive();
        do_start(1'b0, 8'd0);
        run_body(0, 2, 3, -1, "rst_mid", e);
        n_vec++;
        if (err_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL rst_mid pre_reset err_cnt: got %0d, required 3", err_cnt);
        end
        #2 rst_n = 1'b0;
        #1 check_idle("rst_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("rst_mid_no_restart");
        build_exhaustive();
        do_start(1'b0, 8'd0);
        run_body(0, 0, 0, -1, "rst_mid_restart", e);
    endtask

`ifdef PTG_LFSR_EN
    task automatic test_lfsr();
        int e;
        logic [7:0] nv;
        build_random(8'd0);
        do_start(1'b1, 8'd0);
        run_body(0, 2, 0, -1, "lfsr_256_sat", e);
        for (int k = 0; k < 3; k++) begin
            nv = 8'($urandom_range(1, 40));
            build_random(nv);
            do_start(1'b1, nv);
            run_body(2, 3, 0, -1, "lfsr_random", e);
        end
        build_exhaustive();
        do_start(1'b0, 8'd0);
        run_body(0, 0, 0, -1, "mode_back_to_walk", e);
    endtask
`else
    task automatic test_mode_ignored();
        int e;
        build_exhaustive();
        do_start(1'b1, 8'd3);
        run_body(0, 0, 0, -1, "mode_ignored", e);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exhaustive();
        test_mismatch();
        test_stall();
        test_random_traffic();
        test_start_during_run();
        test_reset_mid_run();
`ifdef PTG_LFSR_EN
        test_lfsr();
`else
        test_mode_ignored();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pair_triple_pattern_gen.md
PAIR_TRIPLE_PATTERN_GEN -- requirements
Module: pair_triple_pattern_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE or DONE.
REQ-004 SHALL have port mode, input, 1 bit: 0 = exhaustive walk, 1 = pseudo-random; latched at start.
REQ-005 SHALL have port num_vecs, input, 8 bits: vector count for random mode, latched at start; 0 means 256.
REQ-006 SHALL have port vec_val, output, 1 bit: in0/in1/in2/exp hold a valid vector.
REQ-007 SHALL have port vec_rdy, input, 1 bit: consumer accepts the vector; transfer = vec_val & vec_rdy.
REQ-008 SHALL have ports in0, in1, in2, output, 1 bit each: stimulus bits for a pair/triple detector.
REQ-009 SHALL have port exp, output, 1 bit: expected detector output, 1 when at least two of in0..in2 are 1.
REQ-010 SHALL have port dut_out, input, 1 bit: detector response, combinational from in0..in2, sampled on the transfer cycle.
REQ-011 SHALL have port err_cnt, output, 8 bits: saturating mismatch count.
REQ-012 SHALL have ports busy and done, output, 1 bit each: FSM in RUN, FSM in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on final transfer, DONE->RUN on start.
REQ-014 SHALL, on entering RUN, clear err_cnt and the vector counter, latch mode and num_vecs, and assert vec_val in the next cycle.
REQ-015 SHALL assert vec_val only in RUN, and hold in0..in2 and exp stable while vec_val=1 and vec_rdy=0.
REQ-016 SHALL, in exhaustive mode, present {in2,in1,in0} = 0,1,...,7 in order, one per transfer, 8 vectors total.
REQ-017 SHALL, in random mode, take {in2,in1,in0} from bits [2:0] of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 at start), advanced once per transfer, num_vecs vectors total.
REQ-018 SHALL compute exp combinationally as (in0&in1)|(in0&in2)|(in1&in2).
REQ-019 SHALL increment err_cnt on a transfer where dut_out != exp; it saturates at 8'hFF and never wraps.
REQ-020 SHALL advance to the next vector in the cycle after a transfer, allowing one transfer per cycle when vec_rdy is held at 1.
REQ-021 SHALL deassert vec_val in the cycle after the final transfer and go to DONE, holding err_cnt until the next start.
REQ-022 SHALL ignore start while in RUN.
REQ-023 SHALL keep the vector counter at 9 bits internally so that a count of 256 does not wrap.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state=IDLE, vec_val=0, busy=0, done=0, err_cnt=0, in0..in2=0, LFSR=8'hA5, and the counter to 0.
REQ-025 SHALL abandon a run when reset asserts mid-RUN, with no partial transfer completed, and restart only on a new start after rst_n=1.

Configuration
REQ-026 SHALL, when PTG_LFSR_EN is defined, include the LFSR and random mode as specified.
REQ-027 SHALL, when PTG_LFSR_EN is undefined, omit the LFSR, ignore mode and num_vecs, and run exhaustive mode only.

Verification
REQ-028 SHALL pass: mode=0, vec_rdy=1, dut_out=exp -> 8 transfers on consecutive cycles with values 0..7, then done=1, err_cnt=0.
REQ-029 SHALL pass: mode=0, dut_out=in0&in1 -> err_cnt=2 at done (vectors 5 and 6 mismatch).
REQ-030 SHALL pass: mode=0, vec_rdy toggled 1/0 each cycle -> outputs stable while stalled, 8 transfers total, done after the 8th.
REQ-031 SHALL pass, with PTG_LFSR_EN defined: mode=1, num_vecs=0, dut_out=~exp -> 256 transfers, err_cnt=8'hFF (saturated).
REQ-032 SHALL pass: rst_n pulled low after 3 transfers -> vec_val=0 and err_cnt=0 immediately; a new start restarts at vector 0.
REQ-033 SHALL pass: start pulsed during RUN -> no effect, run completes with the original count.
